regfile_access_arbiter: RTL and testbench
=========================================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares the single register-file access port between the CPU execute stage and a debug port.
//  Sits between the execute stage and the register file, and drives the file's write command,
//  address, write data and status inputs. The CPU owns the port by default. A debug read or
//  write is slotted into a cycle in which the CPU flags that it makes no register-file access.
//  An optional starvation guard forces a one-cycle CPU stall so the debug access can proceed.
// PARAMETERS
//  STARVE_LIMIT  15  cycles a pending debug request may wait in WAIT before a stall is forced
//  CNT_W         4   width of the starvation counter (must hold STARVE_LIMIT)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-low
//  cpu_cmd      in   3   CPU write command (register-file encoding)
//  cpu_addr     in   5   CPU file address
//  cpu_wdata    in   8   CPU write data
//  cpu_status   in   8   CPU status update value
//  cpu_idle     in   1   CPU makes no register-file access this cycle
//  cpu_stall    out  1   registered; CPU must hold its state and present idle this cycle
//  dbg_req      in   1   debug request, level; held until dbg_ack
//  dbg_we       in   1   1 = write, 0 = read; stable while dbg_req is high
//  dbg_addr     in   5   debug file address; stable while dbg_req is high
//  dbg_wdata    in   8   debug write data; stable while dbg_req is high
//  dbg_ack      out  1   one-cycle completion pulse
//  dbg_rdata    out  8   read data; valid while dbg_ack is high, held until the next read
//  rf_cmd       out  3   register-file write command
//  rf_addr      out  5   register-file address
//  rf_wdata     out  8   register-file write data
//  rf_status    out  8   register-file status input
//  rf_rdata     in   8   register-file read data (combinational from rf_addr)
// BEHAVIOUR
//  Reset values: state=IDLE, counter=0, cpu_stall=0, dbg_ack=0, dbg_rdata=8'h00.
//  While in reset, rf_* passes the cpu_* inputs through.
//  FSM states: IDLE, WAIT, ACCESS, RESP.
//  IDLE -> WAIT when dbg_req=1. The counter is cleared on entry to WAIT.
//  WAIT -> ACCESS when cpu_idle=1 or cpu_stall=1. Otherwise the counter increments.
//  ACCESS lasts exactly 1 cycle:
//    rf_addr=dbg_addr; rf_cmd=RF_CMD_WRITE if dbg_we, else RF_CMD_NONE; rf_wdata=dbg_wdata.
//    rf_status=cpu_status. On a read, rf_rdata is latched into dbg_rdata at the clock edge.
//    ACCESS -> RESP.
//  RESP: dbg_ack=1 for one cycle, then -> IDLE. A new request is sampled no earlier than the
//    cycle after RESP.
//  In every state except ACCESS, rf_* = cpu_* combinationally (zero latency for the CPU).
//  Debug latency: minimum 3 cycles from dbg_req rise to dbg_ack (IDLE, WAIT+ACCESS, RESP).
//  Address 0 (INDF) on the debug port is passed through as-is; the register file resolves it
//    through FSR. Debug writes to the status register use RF_CMD_WRITE.
//  cpu_stall rises at the edge where the FSM sits in WAIT, counter==STARVE_LIMIT-1 and
//    cpu_idle=0. It is high for exactly the ACCESS cycle and never for 2 consecutive cycles.
//  cpu_idle=1 in the same cycle as the stall condition: grant normally, no stall.
//  dbg_req dropped before dbg_ack: protocol violation. The access still completes and is acked.
//  Reset mid-operation: the access is abandoned immediately, with no ack and no register-file
//    write. A write commits only at the ACCESS clock edge.
// CONFIGURATION
//  DBG_STARVE_GUARD_EN defined: counter and cpu_stall behave as above.
//  Not defined: no counter is built and cpu_stall is tied 0. WAIT exits only on cpu_idle=1;
//    debug may wait indefinitely.
// STRUCTURE
//  define.v holds DATA_WIDTH plus the command encodings:
//    RF_CMD_NONE 3'b000, RF_CMD_STATUS 3'b001, RF_CMD_WRITE 3'b010,
//    RF_CMD_WRITE_STATUS 3'b011, RF_CMD_FSR 3'b100.
//  define.v also holds the FSM state encoding.
//  Sub-module arb_starve_cnt: CNT_W counter with clear, increment and terminal flag.
//    It is instantiated only under DBG_STARVE_GUARD_EN.
// TESTING
//  1. cpu_idle=1 always, dbg write addr 5'h0A data 8'h5A.
//     -> rf_cmd=010 and rf_addr=0A in one cycle; ack 3 cycles after req; GPR[0A] reads 5A.
//  2. cpu_cmd=010 addr 0B data 8'h11 each cycle, cpu_idle=0, dbg read 0A, guard enabled.
//     -> cpu_stall high 1 cycle after 15 WAIT cycles; dbg_rdata=5A with ack; CPU traffic unchanged.
//  3. Same stimulus as 2 with the guard disabled.
//     -> no ack for 100 cycles; release cpu_idle=1 -> ack 2 cycles later.
//  4. FSR=0x0C, dbg write addr 0 data 8'hC3.
//     -> GPR[0C]=C3; a CPU read of 0C returns C3.
//  5. rst low during ACCESS of a write to 0D.
//     -> no ack, GPR[0D]=00, all outputs at reset values.
//  6. dbg_req held high across ack.
//     -> second access starts at the IDLE after RESP; two acks, each exactly 1 cycle wide.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : regfile_access_arbiter_pkg
// Purpose : Shared widths, register-file command encodings and the arbiter
//           FSM state type for the register-file access arbiter slice.
// Contents: DATA_WIDTH, ADDR_WIDTH, CMD_WIDTH, RF_CMD_* encodings, arb_state_t
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_access_arbiter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;
    localparam int CMD_WIDTH  = 3;

    // Register-file write command encodings.
    localparam logic [CMD_WIDTH-1:0] RF_CMD_NONE         = 3'b000;
    localparam logic [CMD_WIDTH-1:0] RF_CMD_STATUS       = 3'b001;
    localparam logic [CMD_WIDTH-1:0] RF_CMD_WRITE        = 3'b010;
    localparam logic [CMD_WIDTH-1:0] RF_CMD_WRITE_STATUS = 3'b011;
    localparam logic [CMD_WIDTH-1:0] RF_CMD_FSR          = 3'b100;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_access_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : regfile_access_arbiter_if
// Purpose : Bundles the CPU execute-stage, debug-port and register-file
//           signals seen by the register-file access arbiter.
// Modports: slave  - the arbiter (consumes cpu_*/dbg_*/rf_rdata, drives the
//                    stall, debug response and rf_* command bus)
//           master - the surrounding CPU / debugger / register file
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_access_arbiter_if;
    import regfile_access_arbiter_pkg::*;

    // CPU execute stage
    logic [CMD_WIDTH-1:0]  cpu_cmd;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_status;
    logic                  cpu_idle;
    logic                  cpu_stall;

    // Debug port
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    // Register file
    logic [CMD_WIDTH-1:0]  rf_cmd;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_status;
    logic [DATA_WIDTH-1:0] rf_rdata;

    modport slave (
        input  cpu_cmd, cpu_addr, cpu_wdata, cpu_status, cpu_idle,
        output cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output rf_cmd, rf_addr, rf_wdata, rf_status,
        input  rf_rdata
    );

    modport master (
        output cpu_cmd, cpu_addr, cpu_wdata, cpu_status, cpu_idle,
        input  cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  rf_cmd, rf_addr, rf_wdata, rf_status,
        output rf_rdata
    );

endinterface

`default_nettype wire

// File: rtl/regfile_access_arbiter_arb_starve_cnt.sv
//------------------------------------------------------------------------------
// Module  : arb_starve_cnt
// Purpose : Starvation counter for a pending debug request. Cleared when a
//           request enters the wait state, incremented for every cycle the
//           request keeps waiting, flags the cycle it reaches LIMIT-1.
// Ports   : clk, rst (async, active-low)
//           i_clr  - clear to zero (priority over increment)
//           i_inc  - increment by one (saturates at all-ones)
//           o_term - counter equals LIMIT-1
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_starve_cnt #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_term = (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/regfile_access_arbiter.sv
//------------------------------------------------------------------------------
// Module  : regfile_access_arbiter
// Purpose : Shares the single register-file access port between the CPU
//           execute stage and a debug port. The CPU owns the port; a debug
//           read/write is slotted into a cycle where the CPU is idle.
// Ports   : clk  - clock
//           rst  - reset, asynchronous, active-low
//           bus  - regfile_access_arbiter_if.slave (cpu_*, dbg_*, rf_*)
// Params  : STARVE_LIMIT - wait cycles before a CPU stall is forced
//           CNT_W        - starvation counter width
// Config  : DBG_STARVE_GUARD_EN - when defined, builds the starvation counter
//           and the registered cpu_stall; otherwise cpu_stall is tied low and
//           a debug request waits for a CPU idle cycle indefinitely.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_access_arbiter_if.slave   bus
);

    if (CNT_W < $clog2(STARVE_LIMIT + 1)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to hold STARVE_LIMIT");
    end

    arb_state_t            r_state;
    arb_state_t            w_stateNext;
    logic                  w_stallSet;
    logic [DATA_WIDTH-1:0] r_dbgRdata;

    //--------------------------------------------------------------------------
    // Optional starvation guard. w_stallSet is the cycle in which a stall is
    // forced: the debug access is granted at the same edge that raises
    // cpu_stall, so the stall covers exactly the ACCESS cycle.
    //--------------------------------------------------------------------------
`ifdef DBG_STARVE_GUARD_EN
    logic w_cntClr;
    logic w_cntInc;
    logic w_cntTerm;
    logic r_cpuStall;

    assign w_cntClr   = (r_state == ST_IDLE) && bus.dbg_req;
    assign w_cntInc   = (r_state == ST_WAIT) && !bus.cpu_idle && !w_cntTerm;
    assign w_stallSet = (r_state == ST_WAIT) && w_cntTerm && !bus.cpu_idle;

    arb_starve_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cntClr),
        .i_inc  (w_cntInc),
        .o_term (w_cntTerm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpuStall <= 1'b0;
        end else begin
            r_cpuStall <= w_stallSet;
        end
    end

    assign bus.cpu_stall = r_cpuStall;
`else
    assign w_stallSet    = 1'b0;
    assign bus.cpu_stall = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.dbg_req) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.cpu_idle || w_stallSet) begin
                    w_stateNext = ST_ACCESS;
                end
            end
            // Once granted the access always completes, even if the
            // requester drops dbg_req early.
            ST_ACCESS: w_stateNext = ST_RESP;
            ST_RESP:   w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Register-file port mux: CPU passes straight through except in ACCESS.
    // Reset forces IDLE asynchronously, so an in-flight debug write is
    // dropped before it can commit.
    //--------------------------------------------------------------------------
    always_comb begin
        bus.rf_cmd    = bus.cpu_cmd;
        bus.rf_addr   = bus.cpu_addr;
        bus.rf_wdata  = bus.cpu_wdata;
        bus.rf_status = bus.cpu_status;
        if (r_state == ST_ACCESS) begin
            bus.rf_cmd   = bus.dbg_we ? RF_CMD_WRITE : RF_CMD_NONE;
            bus.rf_addr  = bus.dbg_addr;
            bus.rf_wdata = bus.dbg_wdata;
        end
    end

    //--------------------------------------------------------------------------
    // Debug response
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbgRdata <= '0;
        end else if ((r_state == ST_ACCESS) && !bus.dbg_we) begin
            r_dbgRdata <= bus.rf_rdata;
        end
    end

    assign bus.dbg_rdata = r_dbgRdata;
    assign bus.dbg_ack   = (r_state == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_regfile_access_arbiter
// Purpose : Self-checking bench for regfile_access_arbiter. Contains a small
//           register file (32 bytes, FSR at 4, STATUS at 3, INDF at 0) and a
//           transaction-level expectation of grant cycle, stall and read data.
// Config  : honours DBG_STARVE_GUARD_EN to select the expected stall policy.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_access_arbiter;
    import regfile_access_arbiter_pkg::*;

    localparam int c_STARVE_LIMIT = 15;

    logic clk = 1'b0;
    logic rst;

    regfile_access_arbiter_if bus ();

    regfile_access_arbiter #(
        .STARVE_LIMIT (c_STARVE_LIMIT),
        .CNT_W        (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file environment
    logic [7:0] r_mem [0:31];
    logic       r_envClear;
    logic [4:0] w_rfEff;

    assign w_rfEff     = (bus.rf_addr == 5'd0) ? r_mem[4][4:0] : bus.rf_addr;
    assign bus.rf_rdata = r_mem[w_rfEff];

    always @(posedge clk) begin
        if (r_envClear) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= 8'h00;
        end else begin
            case (bus.rf_cmd)
                RF_CMD_WRITE:        r_mem[w_rfEff] <= bus.rf_wdata;
                RF_CMD_STATUS:       r_mem[3] <= bus.rf_status;
                RF_CMD_WRITE_STATUS: begin
                    r_mem[3]       <= bus.rf_status;
                    r_mem[w_rfEff] <= bus.rf_wdata;
                end
                RF_CMD_FSR:          r_mem[4] <= bus.rf_wdata;
                default: ;
            endcase
        end
    end

    // Expectation state
    logic [7:0] model [0:31];
    logic [7:0] fsrModel;
    logic [7:0] lastRead;
    int         nChecks;
    int         nErrors;

    task automatic drive_cpu(input bit idle, input bit fixedTraffic);
        bus.cpu_idle   = idle;
        bus.cpu_status = 8'($urandom);
        if (idle) begin
            bus.cpu_cmd   = RF_CMD_NONE;
            bus.cpu_addr  = 5'($urandom);
            bus.cpu_wdata = 8'($urandom);
        end else if (fixedTraffic) begin
            bus.cpu_cmd   = RF_CMD_WRITE;
            bus.cpu_addr  = 5'h0B;
            bus.cpu_wdata = 8'h11;
        end else begin
            case ($urandom_range(2))
                0:       bus.cpu_cmd = RF_CMD_WRITE;
                1:       bus.cpu_cmd = RF_CMD_STATUS;
                default: bus.cpu_cmd = RF_CMD_WRITE_STATUS;
            endcase
            bus.cpu_addr  = 5'(24 + $urandom_range(7));
            bus.cpu_wdata = 8'($urandom);
        end
    endtask

    // One debug transaction. The grant is the first WAIT cycle with CPU idle,
    // or (with the guard) the STARVE_LIMIT-th WAIT cycle with a forced stall.
    // Ack follows grant by two cycles; cycle 0 is the IDLE cycle with req high.
    task automatic run_txn(input logic we, input logic [4:0] a, input logic [7:0] d,
                           input int idlePct, input int forceIdleAt, input bit fixedTraffic,
                           input int preGap, input bit dropReq);
        bit         idl [0:127];
        int         firstIdle;
        int         g;
        bit         stallExp;
        bit         idleNow;
        logic [4:0] eff;
        logic [7:0] expRd;
        logic [2:0] expCmd;
        logic [4:0] expAddr;
        logic [7:0] expWdata;

        for (int i = 0; i < 128; i++)
            idl[i] = (i >= forceIdleAt) || (int'($urandom_range(99)) < idlePct);
        idl[127] = 1'b1;
        firstIdle = 0;
        while (!idl[firstIdle]) firstIdle++;
        g        = firstIdle;
        stallExp = 1'b0;
`ifdef DBG_STARVE_GUARD_EN
        if (firstIdle > c_STARVE_LIMIT - 1) begin
            g        = c_STARVE_LIMIT - 1;
            stallExp = 1'b1;
        end
`endif
        eff = (a == 5'd0) ? fsrModel[4:0] : a;

        for (int k = 0; k < preGap; k++) begin
            @(posedge clk); #1;
            bus.dbg_req = 1'b0;
            drive_cpu($urandom_range(1) == 1, fixedTraffic);
            @(negedge clk);
            nChecks++;
            if (bus.dbg_ack !== 1'b0 || bus.cpu_stall !== 1'b0) begin
                nErrors++;
                $display("FAIL gap_idle: ack=%b stall=%b expected 0/0", bus.dbg_ack, bus.cpu_stall);
            end
        end

        for (int c = 0; c <= g + 3; c++) begin
            @(posedge clk); #1;
            bus.dbg_req   = (c == 0) || !dropReq;
            bus.dbg_we    = we;
            bus.dbg_addr  = a;
            bus.dbg_wdata = d;
            idleNow = (c >= 1 && c <= g + 1) ? idl[c-1] : ($urandom_range(1) == 1);
            drive_cpu(idleNow, fixedTraffic);
            @(negedge clk);

            nChecks++;
            if (bus.dbg_ack !== (c == g + 3)) begin
                nErrors++;
                $display("FAIL dbg_ack c=%0d: got %b expected %b", c, bus.dbg_ack, (c == g + 3));
            end
            nChecks++;
            if (bus.cpu_stall !== (stallExp && (c == g + 2))) begin
                nErrors++;
                $display("FAIL cpu_stall c=%0d: got %b expected %b", c, bus.cpu_stall, (stallExp && (c == g + 2)));
            end
            if (c == g + 2) begin
                expCmd   = we ? RF_CMD_WRITE : RF_CMD_NONE;
                expAddr  = a;
                expWdata = d;
            end else begin
                expCmd   = bus.cpu_cmd;
                expAddr  = bus.cpu_addr;
                expWdata = bus.cpu_wdata;
            end
            nChecks++;
            if (bus.rf_cmd !== expCmd || bus.rf_addr !== expAddr ||
                bus.rf_wdata !== expWdata || bus.rf_status !== bus.cpu_status) begin
                nErrors++;
                $display("FAIL rf_route c=%0d: cmd/addr/wdata/status=%h/%h/%h/%h expected %h/%h/%h/%h",
                         c, bus.rf_cmd, bus.rf_addr, bus.rf_wdata, bus.rf_status,
                         expCmd, expAddr, expWdata, bus.cpu_status);
            end
            if (c == g + 3) begin
                expRd = we ? lastRead : model[eff];
                nChecks++;
                if (bus.dbg_rdata !== expRd) begin
                    nErrors++;
                    $display("FAIL dbg_rdata addr=%h: got %h expected %h", a, bus.dbg_rdata, expRd);
                end
                lastRead = expRd;
            end
        end
        if (we) model[eff] = d;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        r_envClear = 1'b0;
        drive_cpu(1'b0, 1'b0);
        @(negedge clk);
        nChecks++;
        if (bus.dbg_ack !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dbg_rdata !== 8'h00) begin
            nErrors++;
            $display("FAIL reset_outputs: ack=%b stall=%b rdata=%h expected 0/0/00",
                     bus.dbg_ack, bus.cpu_stall, bus.dbg_rdata);
        end
        nChecks++;
        if (bus.rf_cmd !== bus.cpu_cmd || bus.rf_addr !== bus.cpu_addr ||
            bus.rf_wdata !== bus.cpu_wdata || bus.rf_status !== bus.cpu_status) begin
            nErrors++;
            $display("FAIL reset_passthrough: rf=%h/%h/%h/%h expected %h/%h/%h/%h",
                     bus.rf_cmd, bus.rf_addr, bus.rf_wdata, bus.rf_status,
                     bus.cpu_cmd, bus.cpu_addr, bus.cpu_wdata, bus.cpu_status);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.dbg_req = 1'b0;
        drive_cpu(1'b1, 1'b0);
        @(negedge clk);
        nChecks++;
        if (bus.dbg_ack !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            nErrors++;
            $display("FAIL post_reset_idle: ack=%b stall=%b expected 0/0", bus.dbg_ack, bus.cpu_stall);
        end
    endtask

    task automatic test_basic_write();
        run_txn(1'b1, 5'h0A, 8'h5A, 100, 0, 1'b0, 0, 1'b0);
        nChecks++;
        if (r_mem[10] !== 8'h5A) begin
            nErrors++;
            $display("FAIL gpr0a_written: got %h expected 5a", r_mem[10]);
        end
    endtask

    task automatic test_indirect();
        @(posedge clk); #1;
        bus.dbg_req    = 1'b0;
        bus.cpu_idle   = 1'b0;
        bus.cpu_cmd    = RF_CMD_FSR;
        bus.cpu_addr   = 5'h04;
        bus.cpu_wdata  = 8'h0C;
        bus.cpu_status = 8'($urandom);
        @(negedge clk);
        nChecks++;
        if (bus.rf_cmd !== RF_CMD_FSR || bus.rf_wdata !== 8'h0C) begin
            nErrors++;
            $display("FAIL fsr_passthrough: cmd=%h wdata=%h expected 4/0c", bus.rf_cmd, bus.rf_wdata);
        end
        fsrModel = 8'h0C;
        run_txn(1'b1, 5'h00, 8'hC3, 100, 0, 1'b0, 1, 1'b0);
        @(posedge clk); #1;
        bus.dbg_req  = 1'b0;
        bus.cpu_idle = 1'b0;
        bus.cpu_cmd  = RF_CMD_NONE;
        bus.cpu_addr = 5'h0C;
        @(negedge clk);
        nChecks++;
        if (bus.rf_rdata !== 8'hC3 || r_mem[12] !== 8'hC3) begin
            nErrors++;
            $display("FAIL indf_write: cpu read=%h gpr0c=%h expected c3/c3", bus.rf_rdata, r_mem[12]);
        end
        run_txn(1'b0, 5'h00, 8'h00, 50, 30, 1'b0, 1, 1'b0);
    endtask

    task automatic test_starvation();
        run_txn(1'b0, 5'h0A, 8'h00, 0, 100, 1'b1, 1, 1'b0);
        model[11] = 8'h11;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        d = 8'($urandom_range(254) + 1);
        run_txn(1'b1, 5'd17, d, 100, 0, 1'b0, 1, 1'b0);
        run_txn(1'b0, 5'd17, 8'h00, 100, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 5'd17, 8'h00, 40, 20, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
        drive_cpu(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.dbg_req   = 1'b1;
            bus.dbg_we    = 1'b1;
            bus.dbg_addr  = 5'h0D;
            bus.dbg_wdata = 8'h77;
            drive_cpu(1'b1, 1'b0);
            bus.cpu_addr  = 5'h1F;
            if (c == 2) rst = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            nChecks++;
            if (bus.dbg_ack !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dbg_rdata !== 8'h00) begin
                nErrors++;
                $display("FAIL midop_reset_outputs: ack=%b stall=%b rdata=%h expected 0/0/00",
                         bus.dbg_ack, bus.cpu_stall, bus.dbg_rdata);
            end
            nChecks++;
            if (bus.rf_cmd !== RF_CMD_NONE || bus.rf_addr !== 5'h1F) begin
                nErrors++;
                $display("FAIL midop_reset_rf: cmd=%h addr=%h expected 0/1f", bus.rf_cmd, bus.rf_addr);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.dbg_req = 1'b0;
        lastRead = 8'h00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nChecks++;
            if (bus.dbg_ack !== 1'b0) begin
                nErrors++;
                $display("FAIL midop_no_ack: ack=%b expected 0", bus.dbg_ack);
            end
            @(posedge clk); #1;
            drive_cpu(1'b1, 1'b0);
        end
        nChecks++;
        if (r_mem[13] !== 8'h00) begin
            nErrors++;
            $display("FAIL midop_no_write: gpr0d=%h expected 00", r_mem[13]);
        end
    endtask

    task automatic test_random();
        int         pcts [5];
        logic       we;
        logic [4:0] a;
        logic [7:0] d;
        pcts = '{0, 10, 30, 70, 100};
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(1));
            a  = 5'(16 + $urandom_range(7));
            d  = 8'($urandom);
            run_txn(we, a, d, pcts[$urandom_range(4)], 16 + int'($urandom_range(24)), 1'b0,
                    int'($urandom_range(2)), $urandom_range(9) == 0);
        end
    endtask

    initial begin
        nChecks  = 0;
        nErrors  = 0;
        lastRead = 8'h00;
        fsrModel = 8'h00;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        rst            = 1'b0;
        r_envClear     = 1'b1;
        bus.dbg_req    = 1'b0;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = 5'h00;
        bus.dbg_wdata  = 8'h00;
        bus.cpu_idle   = 1'b1;
        bus.cpu_cmd    = RF_CMD_NONE;
        bus.cpu_addr   = 5'h00;
        bus.cpu_wdata  = 8'h00;
        bus.cpu_status = 8'h00;

        test_reset();
        test_basic_write();
        test_indirect();
        test_starvation();
        test_back_to_back();
        test_reset_midop();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
